// File: rtl/seat_pkg.sv
// -----------------------------------------------------------------------------
// seat_pkg
//   Shared types and constants for the seat request controller.
//   - seat_state_t : 2-bit seat state as stored in the seat-state memory
//   - seat_no_t    : 8-bit seat number as presented by the front end
//   - time_min_t   : 11-bit minute-of-day
//   - ctrl_state_t : request controller FSM states
//   - seat_req_t   : one request FIFO entry {seat, state}
// -----------------------------------------------------------------------------
package seat_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_RESERVED = 2'd1,
    ST_AWAY     = 2'd2,
    ST_OCCUPIED = 2'd3
  } seat_state_t;

  typedef logic [7:0]  seat_no_t;
  typedef logic [10:0] time_min_t;

  localparam int NUM_SEATS = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESENT = 3'd1,
    S_CHECK   = 3'd2,
    S_WRITE   = 3'd3,
    S_REJECT  = 3'd4,
    S_RESPOND = 3'd5
  } ctrl_state_t;

  typedef struct packed {
    seat_no_t    seat;
    seat_state_t state;
  } seat_req_t;

  // Seats outside 0..NUM_SEATS-1 do not exist in the memory.
  function automatic logic seat_in_range(input seat_no_t seat);
    return seat < seat_no_t'(NUM_SEATS);
  endfunction

endpackage

// File: rtl/seat_req_fifo.sv
// -----------------------------------------------------------------------------
// seat_req_fifo
//   Small synchronous FIFO holding pending seat requests.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset (empties the FIFO)
//     push, push_data  write one entry (accepted when not full, or when a pop
//                      happens in the same cycle)
//     pop              remove the head entry (ignored when empty)
//     head             current head entry (valid when !empty)
//     full, empty      occupancy flags, derived from pointer registers only
// -----------------------------------------------------------------------------
module seat_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/seat_req_ctrl.sv
// -----------------------------------------------------------------------------
// seat_req_ctrl
//   Upstream stage of the seat-state memory. Buffers kiosk/card seat requests,
//   pre-checks each one against the memory's Do_Not_Seat flag and the seat
//   range, commits accepted requests as a one-cycle memory write and returns an
//   accept/reject response. Also keeps the minute-of-day clock.
//
//   Optional build macro SEAT_TIME_SET_EN adds time_set / time_set_val for
//   loading the minute counter (clamped to DAY_MINUTES-1).
//
//   Ports:
//     clk_ctrl, rst_ctrl        clock, asynchronous active-low reset
//     req_valid/req_ready       request handshake, req_seat/req_state payload
//     rsp_valid/rsp_ok/rsp_seat one-cycle response pulse
//     Do_Not_Seat               conflict flag from the memory stage
//     write_mem2, Seat_No_mem2, Seat_State_mem2, Time_mem2  memory write side
//     time_set, time_set_val    (SEAT_TIME_SET_EN only) minute counter load
// -----------------------------------------------------------------------------
module seat_req_ctrl
  import seat_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60,
  parameter int DAY_MINUTES   = 1440,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk_ctrl,
  input  logic        rst_ctrl,
`ifdef SEAT_TIME_SET_EN
  input  logic        time_set,
  input  logic [10:0] time_set_val,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_seat,
  input  logic [1:0]  req_state,
  output logic        rsp_valid,
  output logic        rsp_ok,
  output logic [7:0]  rsp_seat,
  input  logic        Do_Not_Seat,
  output logic        write_mem2,
  output logic [7:0]  Seat_No_mem2,
  output logic [1:0]  Seat_State_mem2,
  output logic [10:0] Time_mem2
);

  // ---------------------------------------------------------------------------
  // Minute-of-day clock
  // ---------------------------------------------------------------------------
  localparam int TW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MIN - 1);
  localparam time_min_t     MIN_LAST  = time_min_t'(DAY_MINUTES - 1);

  logic [TW-1:0] tick_cnt;
  time_min_t     time_min;

  always_ff @(posedge clk_ctrl or negedge rst_ctrl) begin
    if (!rst_ctrl) begin
      tick_cnt <= '0;
      time_min <= '0;
    end else begin
`ifdef SEAT_TIME_SET_EN
      // A load wins over an increment falling in the same cycle.
      if (time_set) begin
        tick_cnt <= '0;
        time_min <= (time_set_val > MIN_LAST) ? MIN_LAST : time_set_val;
      end else
`endif
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        time_min <= (time_min == MIN_LAST) ? time_min_t'(0) : time_min + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  assign Time_mem2 = time_min;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  seat_req_t fifo_in;
  seat_req_t fifo_head;
  logic      fifo_push;
  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;

  assign fifo_in.seat  = req_seat;
  assign fifo_in.state = seat_state_t'(req_state);

  // Held low during reset; otherwise depends only on FIFO pointer state, so
  // there is no path from req_valid.
  assign req_ready = rst_ctrl && !fifo_full;
  assign fifo_push = req_valid && req_ready;

  seat_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(seat_req_t))
  ) u_fifo (
    .clk       (clk_ctrl),
    .rst_n     (rst_ctrl),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Request FSM: one request in flight at a time
  // ---------------------------------------------------------------------------
  ctrl_state_t state;
  ctrl_state_t state_next;
  seat_no_t    hold_seat;
  seat_state_t hold_state;
  logic        ok_reg;
  logic        reject;

  // Occupying a flagged seat is refused; other states may overwrite it.
  assign reject = (Do_Not_Seat && (hold_state == ST_OCCUPIED)) ||
                  !seat_in_range(hold_seat);

  always_ff @(posedge clk_ctrl or negedge rst_ctrl) begin
    if (!rst_ctrl) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Hold register doubles as the memory address/state drivers, so those
  // outputs keep their last value between transactions.
  always_ff @(posedge clk_ctrl or negedge rst_ctrl) begin
    if (!rst_ctrl) begin
      hold_seat  <= '0;
      hold_state <= ST_EMPTY;
      ok_reg     <= 1'b0;
    end else begin
      if (fifo_pop) begin
        hold_seat  <= fifo_head.seat;
        hold_state <= fifo_head.state;
      end
      if (state == S_CHECK) begin
        ok_reg <= !reject;
      end
    end
  end

  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    write_mem2 = 1'b0;
    rsp_valid  = 1'b0;
    rsp_ok     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = S_PRESENT;
        end
      end
      S_PRESENT: begin
        state_next = S_CHECK;
      end
      S_CHECK: begin
        state_next = reject ? S_REJECT : S_WRITE;
      end
      S_WRITE: begin
        write_mem2 = 1'b1;
        state_next = S_RESPOND;
      end
      S_REJECT: begin
        state_next = S_RESPOND;
      end
      S_RESPOND: begin
        rsp_valid  = 1'b1;
        rsp_ok     = ok_reg;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign Seat_No_mem2    = hold_seat;
  assign Seat_State_mem2 = hold_state;
  assign rsp_seat        = hold_seat;

endmodule
